// File: rtl/i2c_write_arbiter.sv
// Round-robin arbiter sharing one single-byte I2C write engine between NREQ requesters.
// Grants, launches the engine, tracks its busy flag and reports done/err/timeout pulses.
module i2c_write_arbiter #(
  parameter int NREQ      = 4,
  parameter int LAUNCH_TO = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [7*NREQ-1:0] req_addr,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic [NREQ-1:0]   err,
  output logic              timeout,
  output logic              idle,
  output logic              m_start,
  output logic [6:0]        m_slave_addr,
  output logic [7:0]        m_data_in,
  input  logic              m_busy,
  input  logic              m_ack_error
);

  localparam int PW = $clog2(NREQ);
  localparam int CW = $clog2(LAUNCH_TO + 1);
  localparam logic [NREQ-1:0] ONE = {{(NREQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_RUN, S_DONE} state_t;

  state_t          state_q;
  logic [PW-1:0]   ptr_q, win_q, win_d, ptr_nxt;
  logic [CW-1:0]   cnt_q;
  logic            busy_m_q, busy_s_q, ack_m_q, ack_s_q;
  logic [NREQ-1:0] gnt_q, done_q, err_q, win_oh_d;
  logic            timeout_q, idle_q, start_q, found;
  logic [6:0]      addr_q, addr_d;
  logic [7:0]      data_q, data_d;
  int              idx;

  assign gnt          = gnt_q;
  assign done         = done_q;
  assign err          = err_q;
  assign timeout      = timeout_q;
  assign idle         = idle_q;
  assign m_start      = start_q;
  assign m_slave_addr = addr_q;
  assign m_data_in    = data_q;

  // busy and ack come from the engine's SCL domain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_m_q <= 1'b0;
      busy_s_q <= 1'b0;
      ack_m_q  <= 1'b0;
      ack_s_q  <= 1'b0;
    end else begin
      busy_m_q <= m_busy;
      busy_s_q <= busy_m_q;
      ack_m_q  <= m_ack_error;
      ack_s_q  <= ack_m_q;
    end
  end

  always_comb begin
    win_d = ptr_q;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr_q) + k) % NREQ;
      if (!found && req[PW'(idx)]) begin
        found = 1'b1;
        win_d = PW'(idx);
      end
    end
    win_oh_d = ONE << win_d;
    addr_d   = 7'(req_addr >> (7 * win_d));
    data_d   = 8'(req_data >> (8 * win_d));
    ptr_nxt  = (win_q == PW'(NREQ - 1)) ? '0 : win_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      win_q     <= '0;
      cnt_q     <= '0;
      gnt_q     <= '0;
      done_q    <= '0;
      err_q     <= '0;
      timeout_q <= 1'b0;
      idle_q    <= 1'b1;
      start_q   <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (|req) begin
            win_q   <= win_d;
            gnt_q   <= win_oh_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            start_q <= 1'b1;
            cnt_q   <= '0;
            idle_q  <= 1'b0;
            state_q <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          if (busy_s_q) begin
            start_q <= 1'b0;
            state_q <= S_RUN;
          end else if (cnt_q >= CW'(LAUNCH_TO - 1)) begin
            // start has now been high for LAUNCH_TO cycles
            start_q   <= 1'b0;
            done_q    <= gnt_q;
            err_q     <= gnt_q;
            timeout_q <= 1'b1;
            state_q   <= S_DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_RUN: begin
          if (!busy_s_q) begin
            done_q  <= gnt_q;
            err_q   <= ack_s_q ? gnt_q : '0;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          done_q    <= '0;
          err_q     <= '0;
          timeout_q <= 1'b0;
          gnt_q     <= '0;
          ptr_q     <= ptr_nxt;
          idle_q    <= 1'b1;
          state_q   <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_write_arbiter.sv
// Bench for i2c_write_arbiter: behavioural engine model plus a round-robin reference model
// with directed scenarios followed by randomized transactions.
module tb_i2c_write_arbiter;
  localparam int NREQ = 4;
  localparam int LTO  = 20;

  logic            clk = 1'b0;
  logic            rst;
  logic [NREQ-1:0] req;
  logic [7*NREQ-1:0] req_addr;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0] gnt, done, err;
  logic            timeout, idle, m_start;
  logic [6:0]      m_slave_addr;
  logic [7:0]      m_data_in;
  logic            m_busy, m_ack_error;

  logic [6:0] addr_m [NREQ];
  logic [7:0] data_m [NREQ];
  bit eng_dead, eng_nack;
  int n_chk, n_fail, model_ptr;

  i2c_write_arbiter #(.NREQ(NREQ), .LAUNCH_TO(LTO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_data(req_data),
    .gnt(gnt), .done(done), .err(err), .timeout(timeout), .idle(idle),
    .m_start(m_start), .m_slave_addr(m_slave_addr), .m_data_in(m_data_in),
    .m_busy(m_busy), .m_ack_error(m_ack_error)
  );

  always #5 clk = ~clk;

  always_comb begin
    req_addr = '0;
    req_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_addr[7*i +: 7] = addr_m[i];
      req_data[8*i +: 8] = data_m[i];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // reference arbitration: first requester at or after the pointer, wrapping
  function automatic int pick(input logic [NREQ-1:0] r, input int p);
    for (int k = 0; k < NREQ; k++)
      if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    return 0;
  endfunction

  // engine model: after start, busy rises after 0..3 cycles and lasts 3..9 cycles
  initial begin
    m_busy = 1'b0;
    m_ack_error = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (m_start && !eng_dead && !rst) begin
        m_ack_error = 1'b0;
        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        m_busy = 1'b1;
        repeat ($urandom_range(2, 8)) begin @(posedge clk); #1; end
        m_ack_error = eng_nack;
        @(posedge clk); #1;
        m_busy = 1'b0;
      end
    end
  end

  task automatic do_txn(input int w, input bit nack, input bit to, input bit mid);
    logic [NREQ-1:0] oh;
    logic [6:0] ea;
    logic [7:0] ed;
    int t, st_cnt, bz_t, drop_t;
    bit mid_done;
    oh = '0;
    oh[w] = 1'b1;
    ea = addr_m[w];
    ed = data_m[w];
    t = 0;
    do begin @(negedge clk); t++; end while (gnt == '0 && t < 50);
    chk("gnt_latency", t, 1);
    chk("gnt", gnt, oh);
    chk("addr", m_slave_addr, ea);
    chk("data", m_data_in, ed);
    chk("start_at_gnt", m_start, 1);
    chk("idle_busy", idle, 0);
    st_cnt = 0; bz_t = -100; drop_t = -1; mid_done = 0; t = 0;
    while (done == '0 && t < 200) begin
      if (m_start) st_cnt++;
      if (m_busy && bz_t < 0) bz_t = t;
      if (!m_start && drop_t < 0) drop_t = t;
      chk("gnt_hold", gnt, oh);
      chk("data_hold", m_data_in, ed);
      if (mid && !mid_done && m_busy && !m_start) begin
        data_m[1] = 8'h3C;
        req[1] = 1'b0;
        mid_done = 1;
      end
      @(negedge clk);
      t++;
    end
    chk("done", done, oh);
    chk("err", err, (nack || to) ? oh : '0);
    chk("timeout", timeout, to);
    chk("gnt_in_done", gnt, oh);
    chk("start_in_done", m_start, 0);
    if (to) chk("start_cycles", st_cnt, LTO);
    else    chk("start_drop", drop_t - bz_t, 3);
    @(negedge clk);
    chk("done_pulse", done, 0);
    chk("err_pulse", err, 0);
    chk("timeout_pulse", timeout, 0);
    chk("idle_after", idle, 1);
    chk("gnt_cleared", gnt, 0);
    model_ptr = (w + 1) % NREQ;
  endtask

  initial begin
    int t;
    n_chk = 0; n_fail = 0; model_ptr = 0;
    eng_dead = 0; eng_nack = 0;
    req = '0;
    rst = 1'b1;
    for (int i = 0; i < NREQ; i++) begin addr_m[i] = '0; data_m[i] = '0; end
    repeat (3) @(negedge clk);
    chk("rst_gnt", gnt, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_idle", idle, 1);
    chk("rst_start", m_start, 0);
    chk("rst_addr", m_slave_addr, 0);
    chk("rst_data", m_data_in, 0);

    // single request
    addr_m[0] = 7'h50; data_m[0] = 8'hA5;
    req = 4'b0001;
    rst = 1'b0;
    do_txn(pick(req, model_ptr), 0, 0, 0);
    req = '0;

    // round robin with all requesting from reset
    @(negedge clk);
    rst = 1'b1;
    model_ptr = 0;
    for (int i = 0; i < NREQ; i++) begin addr_m[i] = 7'($urandom); data_m[i] = 8'($urandom); end
    req = 4'hF;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) do_txn(pick(req, model_ptr), 0, 0, 0);
    req = '0;

    // NACK
    eng_nack = 1;
    req = 4'b0100;
    do_txn(pick(req, model_ptr), 1, 0, 0);
    req = '0;
    eng_nack = 0;

    // launch timeout with a dead engine
    eng_dead = 1;
    req = 4'b0010;
    do_txn(pick(req, model_ptr), 0, 1, 0);
    req = '0;
    eng_dead = 0;

    // data change and req drop during RUN
    data_m[1] = 8'h11;
    req = 4'b0010;
    do_txn(pick(req, model_ptr), 0, 0, 1);
    req = '0;

    // randomized traffic
    for (int n = 0; n < 25; n++) begin
      for (int i = 0; i < NREQ; i++) begin addr_m[i] = 7'($urandom); data_m[i] = 8'($urandom); end
      req = 4'($urandom_range(1, 15));
      eng_nack = bit'($urandom_range(0, 1));
      do_txn(pick(req, model_ptr), eng_nack, 0, 0);
    end
    req = '0;
    eng_nack = 0;

    // asynchronous reset while in RUN
    req = 4'b0001;
    t = 0;
    do begin @(negedge clk); t++; end while (!(m_busy && !m_start && gnt != '0) && t < 60);
    chk("reach_run", t < 60, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_gnt", gnt, 0);
    chk("arst_start", m_start, 0);
    chk("arst_idle", idle, 1);
    req = 4'hF;
    repeat (15) @(negedge clk);
    rst = 1'b0;
    model_ptr = 0;
    do_txn(pick(req, model_ptr), 0, 0, 0);
    req = '0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
